adc_window_peak: RTL and testbench

Parametrised successor to the single-word ADC peak path: finds the largest-magnitude sample across a programmable multi-word window of ADC data, rather than a single AXI-Stream word. It returns the signed sample value, its word index and its lane, plus a threshold flag. It also streams a trigger-armed, length-programmable raw capture to the PS DMA with `tlast` and an overflow flag. It sits between the RFdc ADC AXI-Stream output and the experiment FSM / DMA.

---
 rtl/adc_window_peak.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_adc_window_peak.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_window_peak.sv
// adc_window_peak: largest-magnitude sample search over a programmable
// multi-word window of ADC data, plus a trigger-armed raw capture stream.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready ADC input stream (tready tied high)
//   window_len, threshold, run window length (sampled on run), magnitude
//                             threshold, window start
//   peak_val/word/lane/above  result of the last completed window
//   peak_valid, busy          one-cycle result strobe, window/pipeline activity
//   cap_len, cap_trig         capture length (sampled on trigger), trigger level
//   m_axis_tdata/tvalid/tlast/tready  capture stream towards the DMA
//   cap_overflow, cap_clr     sticky dropped-word flag and its clear
module adc_window_peak #(
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned LANES      = 8,
    parameter int unsigned WINDOW_MAX = 16,
    parameter int unsigned CAP_MAX    = 1024
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [LANES*SAMPLE_W-1:0]          s_axis_tdata,
    input  logic                               s_axis_tvalid,
    output logic                               s_axis_tready,
    input  logic [$clog2(WINDOW_MAX):0]        window_len,
    input  logic [SAMPLE_W-2:0]                threshold,
    input  logic                               run,
    output logic [SAMPLE_W-1:0]                peak_val,
    output logic [$clog2(WINDOW_MAX)-1:0]      peak_word,
    output logic [$clog2(LANES)-1:0]           peak_lane,
    output logic                               peak_above,
    output logic                               peak_valid,
    output logic                               busy,
    input  logic [$clog2(CAP_MAX):0]           cap_len,
    input  logic                               cap_trig,
    output logic [LANES*SAMPLE_W-1:0]          m_axis_tdata,
    output logic                               m_axis_tvalid,
    output logic                               m_axis_tlast,
    input  logic                               m_axis_tready,
    output logic                               cap_overflow,
    input  logic                               cap_clr
);

    localparam int unsigned WL_W   = $clog2(WINDOW_MAX) + 1;
    localparam int unsigned WI_W   = $clog2(WINDOW_MAX);
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned CL_W   = $clog2(CAP_MAX) + 1;
    localparam int unsigned MAG_W  = SAMPLE_W - 1;

    typedef enum logic {W_IDLE, W_ACTIVE} win_state_t;
    typedef enum logic [1:0] {C_IDLE, C_CAPTURE, C_HOLD} cap_state_t;

    assign s_axis_tready = 1'b1;

    // ---------------------------------------------------------------
    // Window control
    // ---------------------------------------------------------------
    win_state_t        win_state;
    logic [WL_W-1:0]   win_len_q;
    logic [WL_W-1:0]   win_cnt;
    logic [WL_W-1:0]   win_len_c;
    logic              win_acc_c;
    logic              win_first_c;
    logic              win_last_c;

    // Length 0 means 1; anything beyond the window depth is clamped.
    always_comb begin
        win_len_c = window_len;
        if (window_len == '0) begin
            win_len_c = WL_W'(1);
        end else if (window_len > WL_W'(WINDOW_MAX)) begin
            win_len_c = WL_W'(WINDOW_MAX);
        end
    end

    assign win_acc_c   = (win_state == W_ACTIVE) && s_axis_tvalid;
    assign win_first_c = (win_cnt == '0);
    assign win_last_c  = win_acc_c && (win_cnt == win_len_q - WL_W'(1));

    // Window FSM; a held run restarts on the last word so windows abut.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_state <= W_IDLE;
            win_len_q <= '0;
            win_cnt   <= '0;
        end else begin
            case (win_state)
                W_IDLE: begin
                    if (run) begin
                        win_len_q <= win_len_c;
                        win_cnt   <= '0;
                        win_state <= W_ACTIVE;
                    end
                end
                W_ACTIVE: begin
                    if (win_acc_c) begin
                        if (win_last_c) begin
                            win_cnt <= '0;
                            if (run) begin
                                win_len_q <= win_len_c;
                            end else begin
                                win_state <= W_IDLE;
                            end
                        end else begin
                            win_cnt <= win_cnt + WL_W'(1);
                        end
                    end
                end
                default: win_state <= W_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Stage 0 (combinational): per-lane magnitude, most-negative saturates
    // ---------------------------------------------------------------
    logic [MAG_W-1:0] mag_c [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_mag
        logic [SAMPLE_W-1:0] raw;
        logic [SAMPLE_W-1:0] neg;
        assign raw = s_axis_tdata[g*SAMPLE_W +: SAMPLE_W];
        assign neg = ~raw + SAMPLE_W'(1);
        assign mag_c[g] = !raw[SAMPLE_W-1]          ? raw[MAG_W-1:0] :
                          (raw[MAG_W-1:0] == '0)    ? '1             :
                                                      neg[MAG_W-1:0];
    end

    // ---------------------------------------------------------------
    // Stage 1: registered magnitudes and raw lanes
    // ---------------------------------------------------------------
    logic [MAG_W-1:0]    s1_mag [LANES];
    logic [SAMPLE_W-1:0] s1_raw [LANES];
    logic                s1_v, s1_first, s1_last;
    logic [WI_W-1:0]     s1_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LANES; i++) begin
                s1_mag[i] <= '0;
                s1_raw[i] <= '0;
            end
            s1_v     <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_word  <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                s1_mag[i] <= mag_c[i];
                s1_raw[i] <= s_axis_tdata[i*SAMPLE_W +: SAMPLE_W];
            end
            s1_v     <= win_acc_c;
            s1_first <= win_first_c;
            s1_last  <= win_last_c;
            s1_word  <= win_cnt[WI_W-1:0];
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: per-word lane maximum; strict > keeps the lowest lane on ties
    // ---------------------------------------------------------------
    logic [MAG_W-1:0]    red_mag;
    logic [SAMPLE_W-1:0] red_val;
    logic [LANE_W-1:0]   red_lane;

    always_comb begin
        red_mag  = s1_mag[0];
        red_val  = s1_raw[0];
        red_lane = '0;
        for (int i = 1; i < LANES; i++) begin
            if (s1_mag[i] > red_mag) begin
                red_mag  = s1_mag[i];
                red_val  = s1_raw[i];
                red_lane = LANE_W'(i);
            end
        end
    end

    logic [MAG_W-1:0]    s2_mag;
    logic [SAMPLE_W-1:0] s2_val;
    logic [LANE_W-1:0]   s2_lane;
    logic [WI_W-1:0]     s2_word;
    logic                s2_v, s2_first, s2_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_mag   <= '0;
            s2_val   <= '0;
            s2_lane  <= '0;
            s2_word  <= '0;
            s2_v     <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
        end else begin
            s2_mag   <= red_mag;
            s2_val   <= red_val;
            s2_lane  <= red_lane;
            s2_word  <= s1_word;
            s2_v     <= s1_v;
            s2_first <= s1_first;
            s2_last  <= s1_last;
        end
    end

    // ---------------------------------------------------------------
    // Stage 3: running window maximum, reloaded on each window's first word
    // ---------------------------------------------------------------
    logic [MAG_W-1:0]    acc_mag;
    logic [SAMPLE_W-1:0] acc_val;
    logic [LANE_W-1:0]   acc_lane;
    logic [WI_W-1:0]     acc_word;
    logic                take_c;
    logic [MAG_W-1:0]    new_mag;
    logic [SAMPLE_W-1:0] new_val;
    logic [LANE_W-1:0]   new_lane;
    logic [WI_W-1:0]     new_word;

    assign take_c   = s2_first || (s2_mag > acc_mag);
    assign new_mag  = take_c ? s2_mag  : acc_mag;
    assign new_val  = take_c ? s2_val  : acc_val;
    assign new_lane = take_c ? s2_lane : acc_lane;
    assign new_word = take_c ? s2_word : acc_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_mag    <= '0;
            acc_val    <= '0;
            acc_lane   <= '0;
            acc_word   <= '0;
            peak_val   <= '0;
            peak_word  <= '0;
            peak_lane  <= '0;
            peak_above <= 1'b0;
            peak_valid <= 1'b0;
        end else begin
            peak_valid <= s2_v && s2_last;
            if (s2_v) begin
                acc_mag  <= new_mag;
                acc_val  <= new_val;
                acc_lane <= new_lane;
                acc_word <= new_word;
            end
            if (s2_v && s2_last) begin
                peak_val   <= new_val;
                peak_word  <= new_word;
                peak_lane  <= new_lane;
                peak_above <= (new_mag >= threshold);
            end
        end
    end

    // busy covers the active window plus the words still in the pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
        end else begin
            busy <= ((win_state == W_IDLE) && run) || (win_state == W_ACTIVE) ||
                    (s1_v && s1_last) || (s2_v && s2_last);
        end
    end

    // ---------------------------------------------------------------
    // Capture path
    // ---------------------------------------------------------------
    cap_state_t        cap_state;
    logic [CL_W-1:0]   cap_len_q;
    logic [CL_W-1:0]   cap_cnt;
    logic [CL_W-1:0]   cap_len_c;
    logic              cap_trig_d;
    logic              cap_acc_c;
    logic              cap_last_c;

    always_comb begin
        cap_len_c = cap_len;
        if (cap_len == '0) begin
            cap_len_c = CL_W'(1);
        end else if (cap_len > CL_W'(CAP_MAX)) begin
            cap_len_c = CL_W'(CAP_MAX);
        end
    end

    assign cap_acc_c  = (cap_state == C_CAPTURE) && s_axis_tvalid;
    assign cap_last_c = cap_acc_c && (cap_cnt == cap_len_q - CL_W'(1));

    // Trigger history resets high so a trigger held through reset is not
    // mistaken for a fresh edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_state     <= C_IDLE;
            cap_len_q     <= '0;
            cap_cnt       <= '0;
            cap_trig_d    <= 1'b1;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            cap_overflow  <= 1'b0;
        end else begin
            cap_trig_d    <= cap_trig;
            m_axis_tvalid <= cap_acc_c;
            m_axis_tlast  <= cap_last_c;
            if (cap_acc_c) begin
                m_axis_tdata <= s_axis_tdata;
            end
            if (cap_clr) begin
                cap_overflow <= 1'b0;
            end else if (m_axis_tvalid && !m_axis_tready) begin
                cap_overflow <= 1'b1;
            end
            case (cap_state)
                C_IDLE: begin
                    if (cap_trig && !cap_trig_d) begin
                        cap_len_q <= cap_len_c;
                        cap_cnt   <= '0;
                        cap_state <= C_CAPTURE;
                    end
                end
                C_CAPTURE: begin
                    if (cap_acc_c) begin
                        if (cap_last_c) begin
                            cap_cnt   <= '0;
                            cap_state <= C_HOLD;
                        end else begin
                            cap_cnt <= cap_cnt + CL_W'(1);
                        end
                    end
                end
                C_HOLD: begin
                    if (!cap_trig) begin
                        cap_state <= C_IDLE;
                    end
                end
                default: cap_state <= C_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_window_peak.sv
module tb_adc_window_peak;

    localparam int unsigned SW   = 16;
    localparam int unsigned LN   = 8;
    localparam int unsigned WMAX = 16;
    localparam int unsigned CMAX = 1024;
    localparam int unsigned DW   = SW * LN;

    logic           clk = 1'b0;
    logic           rst;
    logic [DW-1:0]  s_axis_tdata;
    logic           s_axis_tvalid;
    logic           s_axis_tready;
    logic [4:0]     window_len;
    logic [14:0]    threshold;
    logic           run;
    logic [15:0]    peak_val;
    logic [3:0]     peak_word;
    logic [2:0]     peak_lane;
    logic           peak_above;
    logic           peak_valid;
    logic           busy;
    logic [10:0]    cap_len;
    logic           cap_trig;
    logic [DW-1:0]  m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tlast;
    logic           m_axis_tready;
    logic           cap_overflow;
    logic           cap_clr;

    adc_window_peak #(
        .SAMPLE_W(SW), .LANES(LN), .WINDOW_MAX(WMAX), .CAP_MAX(CMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .window_len(window_len), .threshold(threshold), .run(run),
        .peak_val(peak_val), .peak_word(peak_word), .peak_lane(peak_lane),
        .peak_above(peak_above), .peak_valid(peak_valid), .busy(busy),
        .cap_len(cap_len), .cap_trig(cap_trig),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .cap_overflow(cap_overflow), .cap_clr(cap_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [DW-1:0] pack8(input int a0, input int a1, input int a2, input int a3,
                                            input int a4, input int a5, input int a6, input int a7);
        logic [DW-1:0] r;
        int a [8];
        a = '{a0, a1, a2, a3, a4, a5, a6, a7};
        for (int i = 0; i < LN; i++) r[i*SW +: SW] = SW'(a[i]);
        return r;
    endfunction

    // Reference model: argmax of saturated |x| in word-then-lane order
    typedef struct {
        logic [15:0] val;
        int          word;
        int          lane;
        bit          above;
        int          at;
    } wexp_t;

    wexp_t          wq [$];
    logic [DW-1:0]  words [$];

    function automatic int mag_of(input logic [SW-1:0] s);
        int v;
        v = int'($signed(s));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    function automatic wexp_t model(input int eff, input logic [14:0] thr, input int at);
        wexp_t r;
        int best;
        int m;
        logic [DW-1:0] wd;
        logic [SW-1:0] s;
        r = '{val: 16'h0, word: 0, lane: 0, above: 1'b0, at: at};
        best = -1;
        for (int w = 0; w < eff; w++) begin
            wd = words[w];
            for (int l = 0; l < LN; l++) begin
                s = wd[l*SW +: SW];
                m = mag_of(s);
                if (m > best) begin
                    best   = m;
                    r.val  = s;
                    r.word = w;
                    r.lane = l;
                end
            end
        end
        r.above = (best >= int'(thr));
        return r;
    endfunction

    function automatic int wclamp(input logic [4:0] wl);
        if (wl == 0) return 1;
        if (int'(wl) > int'(WMAX)) return int'(WMAX);
        return int'(wl);
    endfunction

    // Result scoreboard
    always @(negedge clk) begin
        if (rst === 1'b1 && peak_valid === 1'b1) begin
            if (wq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_peak_valid: got strobe expected none (cycle %0d)", cyc);
            end else begin
                wexp_t e;
                e = wq.pop_front();
                chk("peak_cycle", 128'(cyc), 128'(e.at));
                chk("peak_val", 128'(peak_val), 128'(e.val));
                chk("peak_word", 128'(peak_word), 128'(e.word));
                chk("peak_lane", 128'(peak_lane), 128'(e.lane));
                chk("peak_above", 128'(peak_above), 128'(e.above));
            end
        end
    end

    // Capture beat recorder
    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          ready;
    } beat_t;
    beat_t cap_seen [$];

    always @(negedge clk) begin
        if (rst === 1'b1 && m_axis_tvalid === 1'b1)
            cap_seen.push_back('{data: m_axis_tdata, last: m_axis_tlast, ready: m_axis_tready});
    end

    // Drive one window from words[]; returns the cycle of the last accepted word
    task automatic run_window(input logic [4:0] wl, input int gap_max, output int last_cyc);
        int eff;
        eff = wclamp(wl);
        run           = 1'b1;
        window_len    = wl;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = rand_word();
        step();
        run        = 1'b0;
        window_len = 5'($urandom);
        last_cyc   = 0;
        for (int k = 0; k < eff; k++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (g) begin
                s_axis_tvalid = 1'b0;
                s_axis_tdata  = rand_word();
                step();
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = words[k];
            last_cyc      = cyc;
            step();
        end
        s_axis_tvalid = 1'b0;
    endtask

    // One capture; beats with index in [dlo,dhi) see tready low
    task automatic do_capture(input logic [10:0] len, input int dlo, input int dhi);
        logic [DW-1:0] sent [$];
        int eff, k, ndel, ndrop;
        bit rdy_next;
        eff = (len == 0) ? 1 : ((int'(len) > int'(CMAX)) ? int'(CMAX) : int'(len));
        ndrop = 0;
        for (int i = dlo; i < dhi && i < eff; i++) ndrop++;
        cap_seen.delete();
        cap_len       = len;
        cap_trig      = 1'b1;
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = rand_word();
        step();
        cap_len  = 11'($urandom);
        k        = 0;
        rdy_next = 1'b1;
        while (k < eff) begin
            m_axis_tready = rdy_next;
            rdy_next      = 1'b1;
            s_axis_tdata  = rand_word();
            if ($urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
            end else begin
                s_axis_tvalid = 1'b1;
                sent.push_back(s_axis_tdata);
                rdy_next = !(k >= dlo && k < dhi);
                k++;
            end
            step();
        end
        m_axis_tready = rdy_next;
        repeat (3) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = rand_word();
            step();
            m_axis_tready = 1'b1;
        end
        s_axis_tvalid = 1'b0;
        cap_trig      = 1'b0;
        step();
        step();
        chk("cap_beats", 128'(cap_seen.size()), 128'(eff));
        ndel = 0;
        for (int i = 0; i < cap_seen.size() && i < eff; i++) begin
            chk("cap_data", cap_seen[i].data, sent[i]);
            chk("cap_tlast", 128'(cap_seen[i].last), 128'(i == eff - 1));
            if (cap_seen[i].ready) ndel++;
        end
        chk("cap_delivered", 128'(ndel), 128'(eff - ndrop));
        chk("cap_overflow", 128'(cap_overflow), 128'(ndrop > 0));
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic [4:0]    wl;
        logic [14:0]   thr;
        logic [15:0]   e_val;
        int            e_lane;
        bit            e_above;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [7];
        int last;
        int c;
        wexp_t e;
        logic [DW-1:0] b [6];

        tbl[0] = '{pack8(5, -3, 7, -9, 2, 0, 1, 4), 5'd1, 15'd8, 16'hFFF7, 3, 1'b1};
        tbl[1] = '{pack8(5, -3, 7, -9, 2, 0, 1, 4), 5'd1, 15'd10, 16'hFFF7, 3, 1'b0};
        tbl[2] = '{pack8(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768),
                   5'd1, 15'h7FFF, 16'h8000, 0, 1'b1};
        tbl[3] = '{pack8(0, 0, 0, 0, 0, 0, 0, 0), 5'd1, 15'd0, 16'h0000, 0, 1'b1};
        tbl[4] = '{pack8(1, 2, 3, 4, 5, 6, 7, -7), 5'd0, 15'd8, 16'h0007, 6, 1'b0};
        tbl[5] = '{pack8(0, 0, 0, 0, 0, 0, 0, -1), 5'd1, 15'd1, 16'hFFFF, 7, 1'b1};
        tbl[6] = '{pack8(-100, 100, 0, 0, 0, 0, 0, 0), 5'd1, 15'd100, 16'hFF9C, 0, 1'b1};

        rst = 1'b0; run = 1'b0; window_len = '0; threshold = '0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; cap_len = '0; cap_trig = 1'b0;
        m_axis_tready = 1'b1; cap_clr = 1'b0;
        step();
        step();
        chk("rst_peak_valid", 128'(peak_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_peak_val", 128'(peak_val), 128'(0));
        chk("rst_m_tvalid", 128'(m_axis_tvalid), 128'(0));
        chk("rst_overflow", 128'(cap_overflow), 128'(0));
        chk("rst_s_tready", 128'(s_axis_tready), 128'(1));
        rst = 1'b1;
        step();

        // Single-word table vectors
        for (int i = 0; i < 7; i++) begin
            words.delete();
            words.push_back(tbl[i].data);
            threshold = tbl[i].thr;
            run_window(tbl[i].wl, 0, last);
            wq.push_back('{val: tbl[i].e_val, word: 0, lane: tbl[i].e_lane,
                           above: tbl[i].e_above, at: last + 3});
            repeat (4) step();
        end

        // Length-4 window with gaps: equal peaks, earliest word wins
        words.delete();
        words.push_back(pack8(3, -4, 10, 0, 7, -20, 1, 2));
        words.push_back(pack8(-50, 40, 9, 8, 0, 0, 0, 99));
        words.push_back(pack8(1, 2, 3, 4, 5, -6, 100, 7));
        words.push_back(pack8(100, -99, 0, 0, 0, 0, 0, 0));
        threshold = 15'd50;
        run_window(5'd4, 2, last);
        wq.push_back('{val: 16'd100, word: 2, lane: 6, above: 1'b1, at: last + 3});
        chk("busy_mid", 128'(busy), 128'(1));
        step();
        step();
        chk("busy_at_n3", 128'(busy), 128'(1));
        chk("valid_at_n3", 128'(peak_valid), 128'(1));
        step();
        chk("busy_after", 128'(busy), 128'(0));
        chk("valid_one_cycle", 128'(peak_valid), 128'(0));
        repeat (3) step();
        chk("peak_held", 128'(peak_val), 128'(100));

        // Saturated most-negative ties with the positive full-scale value
        words.delete();
        words.push_back(pack8(1, 2, 3, 4, 5, 32767, 6, 7));
        words.push_back(pack8(-32768, 0, 0, 0, 0, 0, 0, 0));
        threshold = 15'h7FFF;
        run_window(5'd2, 1, last);
        wq.push_back('{val: 16'h7FFF, word: 0, lane: 5, above: 1'b1, at: last + 3});
        repeat (4) step();

        // run held high: three back-to-back windows of length 2
        b[0] = pack8(1, 2, 3, 4, 5, 6, 7, 8);
        b[1] = pack8(0, 0, -9, 0, 0, 0, 0, 0);
        b[2] = pack8(30, 0, 0, 0, 0, 0, 0, 0);
        b[3] = pack8(0, -31, 0, 0, 0, 0, 0, 0);
        b[4] = pack8(-7, 0, 0, 0, 0, 0, 0, 7);
        b[5] = pack8(0, 0, 0, 0, 0, 0, 0, -7);
        threshold = 15'd9;
        c = cyc;
        for (int j = 0; j < 3; j++) begin
            words.delete();
            words.push_back(b[2*j]);
            words.push_back(b[2*j+1]);
            e = model(2, threshold, c + 5 + 2*j);
            wq.push_back(e);
        end
        run = 1'b1;
        window_len = 5'd2;
        s_axis_tvalid = 1'b0;
        step();
        for (int k = 0; k < 6; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = b[k];
            run           = (k < 5);
            step();
        end
        s_axis_tvalid = 1'b0;
        run = 1'b0;
        repeat (5) step();

        // Randomised windows against the reference model
        for (int t = 0; t < 20; t++) begin
            logic [4:0] wl;
            int eff;
            wl  = 5'($urandom_range(0, 31));
            eff = wclamp(wl);
            words.delete();
            for (int w = 0; w < eff; w++) begin
                logic [DW-1:0] wd;
                wd = rand_word();
                for (int l = 0; l < LN; l++) begin
                    int r;
                    r = int'($urandom_range(0, 9));
                    if (r == 0)      wd[l*SW +: SW] = 16'h8000;
                    else if (r == 1) wd[l*SW +: SW] = 16'h7FFF;
                    else if (r < 6)  wd[l*SW +: SW] = SW'(int'($urandom_range(0, 400)) - 200);
                end
                words.push_back(wd);
            end
            threshold = 15'($urandom);
            run_window(wl, 2, last);
            e = model(eff, threshold, last + 3);
            wq.push_back(e);
            repeat (4) step();
        end

        // Capture: clean, length 0, then with two dropped beats and clear
        do_capture(11'd8, 99, 99);
        do_capture(11'd0, 99, 99);
        do_capture(11'd8, 3, 5);
        cap_clr = 1'b1;
        step();
        cap_clr = 1'b0;
        chk("cap_clr", 128'(cap_overflow), 128'(0));

        // Reset in the middle of a window and a capture
        cap_seen.delete();
        threshold = 15'd0;
        run = 1'b1; window_len = 5'd4;
        cap_trig = 1'b1; cap_len = 11'd8;
        s_axis_tvalid = 1'b1; s_axis_tdata = rand_word();
        step();
        run = 1'b0;
        repeat (2) begin
            s_axis_tdata = pack8(1000, 1, 1, 1, 1, 1, 1, 1);
            step();
        end
        rst = 1'b0;
        #1;
        chk("mid_rst_peak_val", 128'(peak_val), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_m_tvalid", 128'(m_axis_tvalid), 128'(0));
        chk("mid_rst_m_tdata", m_axis_tdata, 128'(0));
        chk("mid_rst_tlast", 128'(m_axis_tlast), 128'(0));
        step();
        step();
        rst = 1'b1;
        cap_seen.delete();
        repeat (6) step();
        s_axis_tvalid = 1'b0;
        chk("post_rst_no_capture", 128'(cap_seen.size()), 128'(0));
        chk("post_rst_busy", 128'(busy), 128'(0));
        cap_trig = 1'b0;
        step();
        do_capture(11'd5, 99, 99);
        words.delete();
        words.push_back(pack8(0, 0, 0, -2000, 0, 0, 0, 0));
        words.push_back(pack8(1999, 0, 0, 0, 0, 0, 0, 0));
        threshold = 15'd2001;
        run_window(5'd2, 1, last);
        wq.push_back('{val: 16'hF830, word: 0, lane: 3, above: 1'b0, at: last + 3});
        repeat (5) step();

        chk("pending_results", 128'(wq.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
